max_unpool_single: RTL and testbench

// - Single-channel max-unpool: reverse direction of the single-channel max-pool stage.
// - Takes a stream of pooled FP32 values in raster order plus the pre-pool reference matrix.
// - For each pooled value, re-finds the argmax position inside its window (fp_comp scan) and

---
 rtl/max_unpool_single.sv | 218 +++++++++++++++++++++
 tb/tb_max_unpool_single.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/max_unpool_single.sv
// rtl/max_unpool_single.sv - single-channel FP32 max-unpool; optional argmax index outputs via MAX_UNPOOL_IDX_OUT_EN
module max_unpool_single #(
  parameter int DATAWIDTH        = 32,
  parameter int MAT_DIMENSION    = 27,
  parameter int WINDOW_DIMENSION = 3,
  parameter int STRIDE           = 2,
  parameter int OUTPUT_DIMENSION = (MAT_DIMENSION - WINDOW_DIMENSION) / STRIDE + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] mat_ref [MAT_DIMENSION][MAT_DIMENSION],
  input  logic [DATAWIDTH-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [DATAWIDTH-1:0] mat_out [MAT_DIMENSION][MAT_DIMENSION],
  output logic                 busy,
  output logic                 finished
`ifdef MAX_UNPOOL_IDX_OUT_EN
  ,
  output logic                 idx_valid,
  output logic [$clog2(MAT_DIMENSION)-1:0] idx_row,
  output logic [$clog2(MAT_DIMENSION)-1:0] idx_col
`endif
);

  localparam int OUT_CW = $clog2(OUTPUT_DIMENSION) + 1;
  localparam int WIN_CW = $clog2(WINDOW_DIMENSION) + 1;
  localparam int IDX_W  = $clog2(MAT_DIMENSION);

  localparam logic [OUT_CW-1:0] OUT_LAST = OUT_CW'(OUTPUT_DIMENSION - 1);
  localparam logic [WIN_CW-1:0] WIN_LAST = WIN_CW'(WINDOW_DIMENSION - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT_IN,
    S_SCAN,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                 state_q;
  logic [OUT_CW-1:0]      out_row_q;
  logic [OUT_CW-1:0]      out_col_q;
  logic [WIN_CW-1:0]      win_r_q;
  logic [WIN_CW-1:0]      win_c_q;
  logic [DATAWIDTH-1:0]   data_q;
  logic [DATAWIDTH-1:0]   cand_q;
  logic [IDX_W-1:0]       arg_r_q;
  logic [IDX_W-1:0]       arg_c_q;
  logic [DATAWIDTH-1:0]   mat_out_q [MAT_DIMENSION][MAT_DIMENSION];
  logic                   in_ready_q;
  logic                   busy_q;
  logic                   finished_q;
`ifdef MAX_UNPOOL_IDX_OUT_EN
  logic                   idx_valid_q;
`endif

  logic [IDX_W-1:0]       scan_r;
  logic [IDX_W-1:0]       scan_c;
  logic [DATAWIDTH-1:0]   cur_elem;
  logic                   cur_gt;
  logic                   win_first;
  logic                   win_last;
  logic                   out_last;

  // Sign-magnitude strict greater-than; +0 and -0 compare equal.
  function automatic logic fp_comp_gt(input logic [DATAWIDTH-1:0] a,
                                      input logic [DATAWIDTH-1:0] b);
    logic                 sa;
    logic                 sb;
    logic [DATAWIDTH-2:0] ma;
    logic [DATAWIDTH-2:0] mb;
    sa = a[DATAWIDTH-1];
    sb = b[DATAWIDTH-1];
    ma = a[DATAWIDTH-2:0];
    mb = b[DATAWIDTH-2:0];
    if ((ma == '0) && (mb == '0)) begin
      return 1'b0;
    end else if (sa != sb) begin
      return sb;
    end else if (!sa) begin
      return ma > mb;
    end else begin
      return ma < mb;
    end
  endfunction

  // Address of the window element visited this SCAN cycle and its comparison against the candidate.
  always_comb begin
    scan_r    = IDX_W'(int'(out_row_q) * STRIDE + int'(win_r_q));
    scan_c    = IDX_W'(int'(out_col_q) * STRIDE + int'(win_c_q));
    cur_elem  = mat_ref[scan_r][scan_c];
    cur_gt    = fp_comp_gt(cur_elem, cand_q);
    win_first = (win_r_q == '0) && (win_c_q == '0);
    win_last  = (win_r_q == WIN_LAST) && (win_c_q == WIN_LAST);
    out_last  = (out_row_q == OUT_LAST) && (out_col_q == OUT_LAST);
  end

  // Control FSM plus datapath registers; every output is a register updated on state transitions.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      out_row_q  <= '0;
      out_col_q  <= '0;
      win_r_q    <= '0;
      win_c_q    <= '0;
      data_q     <= '0;
      cand_q     <= '0;
      arg_r_q    <= '0;
      arg_c_q    <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      finished_q <= 1'b0;
`ifdef MAX_UNPOOL_IDX_OUT_EN
      idx_valid_q <= 1'b0;
`endif
      for (int r = 0; r < MAT_DIMENSION; r++) begin
        for (int c = 0; c < MAT_DIMENSION; c++) begin
          mat_out_q[r][c] <= '0;
        end
      end
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q    <= S_CLEAR;
            busy_q     <= 1'b1;
            finished_q <= 1'b0;
          end
        end

        S_CLEAR: begin
          for (int r = 0; r < MAT_DIMENSION; r++) begin
            for (int c = 0; c < MAT_DIMENSION; c++) begin
              mat_out_q[r][c] <= '0;
            end
          end
          out_row_q  <= '0;
          out_col_q  <= '0;
          state_q    <= S_WAIT_IN;
          in_ready_q <= 1'b1;
        end

        S_WAIT_IN: begin
          if (in_valid) begin
            data_q     <= in_data;
            win_r_q    <= '0;
            win_c_q    <= '0;
            in_ready_q <= 1'b0;
            state_q    <= S_SCAN;
          end
        end

        S_SCAN: begin
          // The first visited element seeds the candidate; later ones replace it only when
          // strictly greater, so ties keep the earliest element in window raster order.
          if (win_first || cur_gt) begin
            cand_q  <= cur_elem;
            arg_r_q <= scan_r;
            arg_c_q <= scan_c;
          end
          if (win_last) begin
            win_r_q <= '0;
            win_c_q <= '0;
            state_q <= S_WRITE;
`ifdef MAX_UNPOOL_IDX_OUT_EN
            idx_valid_q <= 1'b1;
`endif
          end else if (win_c_q == WIN_LAST) begin
            win_c_q <= '0;
            win_r_q <= win_r_q + 1'b1;
          end else begin
            win_c_q <= win_c_q + 1'b1;
          end
        end

        S_WRITE: begin
          mat_out_q[arg_r_q][arg_c_q] <= data_q;
`ifdef MAX_UNPOOL_IDX_OUT_EN
          idx_valid_q <= 1'b0;
`endif
          if (out_last) begin
            state_q    <= S_DONE;
            busy_q     <= 1'b0;
            finished_q <= 1'b1;
          end else begin
            if (out_col_q == OUT_LAST) begin
              out_col_q <= '0;
              out_row_q <= out_row_q + 1'b1;
            end else begin
              out_col_q <= out_col_q + 1'b1;
            end
            state_q    <= S_WAIT_IN;
            in_ready_q <= 1'b1;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign finished = finished_q;
  assign mat_out  = mat_out_q;

`ifdef MAX_UNPOOL_IDX_OUT_EN
  assign idx_valid = idx_valid_q;
  assign idx_row   = arg_r_q;
  assign idx_col   = arg_c_q;
`endif

endmodule

// File: tb/tb_max_unpool_single.sv
// tb/tb_max_unpool_single.sv - directed self-checking bench for max_unpool_single (5x5, window 3, stride 2)
module tb_max_unpool_single;

  localparam int MD = 5;
  localparam logic [31:0] F1 = 32'h3F800000;
  localparam logic [31:0] F2 = 32'h40000000;
  localparam logic [31:0] F3 = 32'h40400000;
  localparam logic [31:0] F4 = 32'h40800000;
  localparam logic [31:0] F5 = 32'h40A00000;
  localparam logic [31:0] F6 = 32'h40C00000;
  localparam logic [31:0] F7 = 32'h40E00000;
  localparam logic [31:0] F9 = 32'h41100000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        busy;
  logic        finished;
  logic [31:0] mat_ref [MD][MD];
  logic [31:0] mat_out [MD][MD];
  logic [31:0] exp_m   [MD][MD];
`ifdef MAX_UNPOOL_IDX_OUT_EN
  logic        idx_valid;
  logic [2:0]  idx_row;
  logic [2:0]  idx_col;
`endif

  int n_cmp = 0;
  int n_fail = 0;
  int seen_n;
  int seen_r [8];
  int seen_c [8];

  always #5 clk = ~clk;

  max_unpool_single #(
    .DATAWIDTH(32),
    .MAT_DIMENSION(MD),
    .WINDOW_DIMENSION(3),
    .STRIDE(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .mat_ref(mat_ref),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .mat_out(mat_out),
    .busy(busy),
    .finished(finished)
`ifdef MAX_UNPOOL_IDX_OUT_EN
    ,
    .idx_valid(idx_valid),
    .idx_row(idx_row),
    .idx_col(idx_col)
`endif
  );

  function automatic int mat_diff();
    int d;
    d = 0;
    for (int r = 0; r < MD; r++)
      for (int c = 0; c < MD; c++)
        if (mat_out[r][c] !== exp_m[r][c]) d++;
    return d;
  endfunction

  task automatic fill_ref(input logic [31:0] v);
    for (int r = 0; r < MD; r++)
      for (int c = 0; c < MD; c++)
        mat_ref[r][c] = v;
  endtask

  task automatic clear_exp();
    for (int r = 0; r < MD; r++)
      for (int c = 0; c < MD; c++)
        exp_m[r][c] = '0;
  endtask

  task automatic setup_basic();
    fill_ref(F1);
    mat_ref[1][1] = F5; mat_ref[1][3] = F5; mat_ref[3][1] = F5; mat_ref[3][3] = F5;
    clear_exp();
    exp_m[1][1] = F2; exp_m[1][3] = F2; exp_m[3][1] = F2; exp_m[3][3] = F2;
  endtask

  // Starts a pass and streams four values; checks in_ready drops right after every accept.
  task automatic run_stream(input logic [31:0] v0, input logic [31:0] v1,
                            input logic [31:0] v2, input logic [31:0] v3,
                            input bit rand_valid, input bit poke_start,
                            output int cyc, output int acc);
    logic [31:0] vals [4];
    bit hs;
    int since;
    vals[0] = v0; vals[1] = v1; vals[2] = v2; vals[3] = v3;
    acc = 0; since = 0; seen_n = 0;
    start = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!finished && cyc < 400) begin
      in_valid = (acc < 4) && (rand_valid ? ($urandom_range(0, 1) == 1) : 1'b1);
      in_data  = vals[acc < 4 ? acc : 3];
      start    = poke_start && (acc == 1) && (since == 3);
      hs       = in_valid && in_ready;
      @(negedge clk);
      cyc++;
      since++;
`ifdef MAX_UNPOOL_IDX_OUT_EN
      if (idx_valid === 1'b1 && seen_n < 8) begin
        seen_r[seen_n] = int'(idx_row);
        seen_c[seen_n] = int'(idx_col);
        seen_n++;
      end
`endif
      if (hs) begin
        acc++;
        since = 0;
        n_cmp++;
        if (in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL in_ready_after_accept: got %b want 0 (value %0d)", in_ready, acc);
        end
      end
    end
    in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({in_ready, busy, finished} !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_flags cycle %0d: got rdy/busy/fin=%b want 000", i, {in_ready, busy, finished});
      end
    end
    clear_exp();
    n_cmp++;
    if (mat_diff() !== 0) begin
      n_fail++;
      $display("FAIL reset_mat: %0d nonzero elements, want 0", mat_diff());
    end
  endtask

  task automatic check_done(input string name, input int cyc, input int acc, input int want_cyc);
    n_cmp++;
    if (acc !== 4) begin
      n_fail++;
      $display("FAIL %s_accepted: got %0d want 4", name, acc);
    end
    n_cmp++;
    if (finished !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done_flags: got fin=%b busy=%b want 1/0", name, finished, busy);
    end
    if (want_cyc > 0) begin
      n_cmp++;
      if (cyc !== want_cyc) begin
        n_fail++;
        $display("FAIL %s_latency: got %0d cycles want %0d", name, cyc, want_cyc);
      end
    end
    n_cmp++;
    if (mat_diff() !== 0) begin
      n_fail++;
      $display("FAIL %s_mat: %0d elements differ, want 0", name, mat_diff());
    end
  endtask

  task automatic test_basic();
    int cyc, acc;
    setup_basic();
    run_stream(F2, F2, F2, F2, 1'b0, 1'b0, cyc, acc);
    check_done("basic", cyc, acc, 45);
`ifdef MAX_UNPOOL_IDX_OUT_EN
    n_cmp++;
    if (seen_n !== 4 || seen_r[0] !== 1 || seen_c[0] !== 1 || seen_r[1] !== 1 || seen_c[1] !== 3 ||
        seen_r[2] !== 3 || seen_c[2] !== 1 || seen_r[3] !== 3 || seen_c[3] !== 3) begin
      n_fail++;
      $display("FAIL basic_idx: got n=%0d (%0d,%0d)(%0d,%0d)(%0d,%0d)(%0d,%0d) want 4 (1,1)(1,3)(3,1)(3,3)",
               seen_n, seen_r[0], seen_c[0], seen_r[1], seen_c[1], seen_r[2], seen_c[2], seen_r[3], seen_c[3]);
    end
`endif
    repeat (5) @(negedge clk);
    n_cmp++;
    if (finished !== 1'b1 || mat_diff() !== 0) begin
      n_fail++;
      $display("FAIL basic_hold: got fin=%b diff=%0d want 1/0", finished, mat_diff());
    end
  endtask

  task automatic test_tie();
    int cyc, acc;
    fill_ref(F1);
    clear_exp();
    exp_m[0][0] = F7; exp_m[0][2] = F7; exp_m[2][0] = F7; exp_m[2][2] = F7;
    run_stream(F7, F7, F7, F7, 1'b0, 1'b0, cyc, acc);
    check_done("tie", cyc, acc, 45);
  endtask

  task automatic test_overlap();
    int cyc, acc;
    fill_ref(F1);
    mat_ref[2][2] = F9;
    clear_exp();
    exp_m[2][2] = F6;
    run_stream(F3, F4, F5, F6, 1'b0, 1'b0, cyc, acc);
    check_done("overlap", cyc, acc, 45);
  endtask

  task automatic test_backpressure();
    int cyc, acc;
    setup_basic();
    run_stream(F2, F2, F2, F2, 1'b1, 1'b1, cyc, acc);
    check_done("backpressure", cyc, acc, 0);
  endtask

  task automatic test_reset_mid();
    int acc, cyc;
    bit hs;
    setup_basic();
    acc = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (acc < 2 && cyc < 100) begin
      in_valid = 1'b1;
      in_data  = F2;
      hs = in_ready;
      @(negedge clk);
      cyc++;
      if (hs) acc++;
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (acc !== 2 || mat_out[1][1] !== F2 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre: got acc=%0d m11=%h busy=%b want 2/40000000/1", acc, mat_out[1][1], busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_exp();
    n_cmp++;
    if ({in_ready, busy, finished} !== 3'b000 || mat_diff() !== 0) begin
      n_fail++;
      $display("FAIL midrst_post: got rdy/busy/fin=%b diff=%0d want 000/0", {in_ready, busy, finished}, mat_diff());
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_idle: got busy=%b want 0", busy);
    end
    test_basic();
  endtask

  initial begin
    fill_ref(F1);
    clear_exp();
    test_reset();
    test_basic();
    test_tie();
    test_overlap();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
